// File: rtl/nios_dbg_cmd_slave.sv
`default_nettype none
// ============================================================================
// Module   : nios_dbg_cmd_slave
// Brief    : Nios II debug command slave: scan DR/IR, tdo readback, per-channel
//            action pulses. Optional ack handshake: NIOS_DBG_ACK_HANDSHAKE_EN.
// Revision : 1.0
// ============================================================================
module nios_dbg_cmd_slave #(
    parameter int DR_W = 38,
    parameter int IR_W = 2,
    localparam int NCH = 2 ** IR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              update_ir,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    input  logic              tdi,
    output logic              tdo,
    input  logic [DR_W-3:0]   capture_data,
    input  logic              action_ack,
    output logic [DR_W-1:0]   jdo,
    output logic [IR_W-1:0]   ir_q,
    output logic [NCH-1:0]    take_action,
    output logic [NCH-1:0]    take_no_action,
    output logic              busy,
    output logic              overrun
);

`ifdef NIOS_DBG_ACK_HANDSHAKE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t            state_q;
    logic [DR_W-1:0]   sr_q;
    logic [DR_W-1:0]   jdo_q;
    logic [IR_W-1:0]   ir_reg_q;
    logic [NCH-1:0]    take_action_q;
    logic [NCH-1:0]    take_no_action_q;
    logic              overrun_q;
    logic [NCH-1:0]    chan_onehot;

    assign chan_onehot = {{(NCH-1){1'b0}}, 1'b1} << ir_reg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            sr_q             <= '0;
            jdo_q            <= '0;
            ir_reg_q         <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overrun_q        <= 1'b0;
        end else begin
            take_action_q    <= '0;
            take_no_action_q <= '0;

            if (capture_dr) begin
                sr_q <= {busy, overrun_q, capture_data};
            end else if (shift_dr) begin
                sr_q <= {tdi, sr_q[DR_W-1:1]};
            end

            if (update_ir) begin
                ir_reg_q <= ir_in;
            end

            // Capture samples the old sticky bit, then clears it; a drop in
            // the same cycle is newer information and wins.
            if (capture_dr) begin
                overrun_q <= 1'b0;
            end
            if (HS_EN && update_dr && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (update_dr) begin
                        jdo_q <= sr_q;
                        if (sr_q[DR_W-1]) begin
                            take_action_q <= chan_onehot;
                        end else begin
                            take_no_action_q <= chan_onehot;
                        end
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= (HS_EN && (take_action_q != '0)) ? S_WAIT_ACK : S_IDLE;
                end
                S_WAIT_ACK: begin
                    if (action_ack) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tdo            = sr_q[0];
    assign jdo            = jdo_q;
    assign ir_q           = ir_reg_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign busy           = (state_q != S_IDLE);
    assign overrun        = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_dbg_cmd_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_dbg_cmd_slave
// Brief    : Self-checking bench for nios_dbg_cmd_slave (DR_W=38, IR_W=2).
// Revision : 1.0
// ============================================================================
module tb_nios_dbg_cmd_slave;
    localparam int DR_W = 38;
    localparam int IR_W = 2;
    localparam int NCH  = 4;
`ifdef NIOS_DBG_ACK_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [IR_W-1:0]   ir_in;
    logic              update_ir, capture_dr, shift_dr, update_dr, tdi;
    logic              tdo;
    logic [DR_W-3:0]   capture_data;
    logic              action_ack;
    logic [DR_W-1:0]   jdo;
    logic [IR_W-1:0]   ir_q;
    logic [NCH-1:0]    take_action, take_no_action;
    logic              busy, overrun;

    int checks   = 0;
    int failures = 0;

    nios_dbg_cmd_slave #(.DR_W(DR_W), .IR_W(IR_W)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .update_ir(update_ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdi(tdi), .tdo(tdo), .capture_data(capture_data), .action_ack(action_ack),
        .jdo(jdo), .ir_q(ir_q), .take_action(take_action),
        .take_no_action(take_no_action), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [IR_W-1:0] v);
        ir_in = v; update_ir = 1'b1; step(); update_ir = 1'b0;
    endtask

    // After DR_W shifts the first bit sent sits in sr[0].
    task automatic shift_word(input logic [DR_W-1:0] w);
        for (int i = 0; i < DR_W; i++) begin
            tdi = w[i]; shift_dr = 1'b1; step();
        end
        shift_dr = 1'b0; tdi = 1'b0;
    endtask

    function automatic logic [NCH-1:0] onehot(input logic [IR_W-1:0] c);
        logic [NCH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; update_dr = 1'b1; capture_dr = 1'b1; update_ir = 1'b1; ir_in = 2'b11;
        step(); step();
        update_dr = 1'b0; capture_dr = 1'b0; update_ir = 1'b0;
        reset = 1'b0;
        checks++; if (jdo !== '0) begin failures++; $display("FAIL reset_jdo got=%h exp=0", jdo); end
        checks++; if (ir_q !== '0) begin failures++; $display("FAIL reset_ir got=%b exp=0", ir_q); end
        checks++; if (take_action !== '0 || take_no_action !== '0) begin failures++;
            $display("FAIL reset_pulses got=%b/%b exp=0/0", take_action, take_no_action); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin failures++;
            $display("FAIL reset_busy_ovr got=%b/%b exp=0/0", busy, overrun); end
        checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
    endtask

    // Action command, held in WAIT_ACK while capture/readback is exercised.
    task automatic test_action_and_capture();
        logic [DR_W-1:0] w, exp_sr;
        logic [DR_W-3:0] cd;
        w = 38'h20_0000_1234;
        load_ir(2'b10);
        shift_word(w);
        update_dr = 1'b1; step(); update_dr = 1'b0;
        checks++; if (jdo !== w) begin failures++; $display("FAIL act_jdo got=%h exp=%h", jdo, w); end
        checks++; if (take_action !== 4'b0100 || take_no_action !== 4'b0000) begin failures++;
            $display("FAIL act_pulse got=%b/%b exp=0100/0000", take_action, take_no_action); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL act_busy_issue got=%b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (take_action !== '0 || busy !== HS) begin failures++;
                $display("FAIL act_hold[%0d] pulse=%b busy=%b exp 0000/%b", i, take_action, busy, HS); end
        end
        cd = 36'hA_BCDE_F012;
        capture_data = cd;
        exp_sr = {HS, 1'b0, cd};
        capture_dr = 1'b1; step(); capture_dr = 1'b0;
        for (int i = 0; i < DR_W; i++) begin
            checks++; if (tdo !== exp_sr[i]) begin failures++;
                $display("FAIL cap_tdo[%0d] got=%b exp=%b", i, tdo, exp_sr[i]); end
            shift_dr = 1'b1; step();
        end
        shift_dr = 1'b0;
        action_ack = 1'b1; step(); action_ack = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL act_ack_busy got=%b exp=0", busy); end
    endtask

    task automatic test_no_action();
        logic [DR_W-1:0] w;
        w = {1'b0, 37'h0_5A5A_C3C3};
        load_ir(2'b01);
        shift_word(w);
        update_dr = 1'b1; step(); update_dr = 1'b0;
        checks++; if (take_no_action !== 4'b0010 || take_action !== 4'b0000) begin failures++;
            $display("FAIL noact_pulse got=%b/%b exp=0000/0010", take_action, take_no_action); end
        checks++; if (jdo !== w || busy !== 1'b1) begin failures++;
            $display("FAIL noact_jdo_busy got=%h/%b exp=%h/1", jdo, busy, w); end
        step();
        checks++; if (busy !== 1'b0 || take_no_action !== '0) begin failures++;
            $display("FAIL noact_after got busy=%b pulse=%b exp 0/0000", busy, take_no_action); end
    endtask

    // Dropped updates: during ISSUE, during WAIT_ACK, and coincident with ack.
    task automatic test_back_to_back();
        logic [DR_W-1:0] w1, w2;
        logic [NCH-1:0] exp_p;
        w1 = {1'b1, 37'h1_2345_6789};
        w2 = {1'b1, 37'h0_0F0F_0F0F};
        load_ir(2'b11);
        shift_word(w1);
        update_dr = 1'b1; step();
        checks++; if (jdo !== w1 || take_action !== 4'b1000) begin failures++;
            $display("FAIL b2b_first jdo=%h pulse=%b exp %h/1000", jdo, take_action, w1); end
        step(); update_dr = 1'b0;
        checks++; if (jdo !== w1 || take_action !== '0 || take_no_action !== '0) begin failures++;
            $display("FAIL b2b_drop jdo=%h pulse=%b/%b exp %h/0/0", jdo, take_action, take_no_action, w1); end
        checks++; if (overrun !== HS) begin failures++; $display("FAIL b2b_ovr got=%b exp=%b", overrun, HS); end
        shift_word(w2);
        update_dr = 1'b1; step(); update_dr = 1'b0;
        exp_p = HS ? 4'b0000 : 4'b1000;
        checks++; if (jdo !== (HS ? w1 : w2) || take_action !== exp_p) begin failures++;
            $display("FAIL wait_drop jdo=%h pulse=%b exp %h/%b", jdo, take_action, HS ? w1 : w2, exp_p); end
        step(); step();
        capture_data = '0;
        capture_dr = 1'b1; step(); capture_dr = 1'b0;
        checks++; if (dut.sr_q[36] !== HS || tdo !== 1'b0) begin failures++;
            $display("FAIL ovr_capture bit36=%b exp=%b", dut.sr_q[36], HS); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        shift_word(w2);
        action_ack = 1'b1; update_dr = 1'b1; step(); action_ack = 1'b0; update_dr = 1'b0;
        checks++; if (jdo !== (HS ? w1 : w2) || overrun !== HS) begin failures++;
            $display("FAIL ack_coinc jdo=%h ovr=%b exp %h/%b", jdo, overrun, HS ? w1 : w2, HS); end
        step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ack_coinc_busy got=%b exp=0", busy); end
        capture_dr = 1'b1; step(); capture_dr = 1'b0;
    endtask

    task automatic test_capture_priority();
        logic [DR_W-3:0] cd;
        logic [DR_W-1:0] exp_sr;
        cd = {$urandom, $urandom} & {(DR_W-2){1'b1}};
        capture_data = cd;
        exp_sr = {1'b0, 1'b0, cd};
        tdi = 1'b1; capture_dr = 1'b1; shift_dr = 1'b1; step();
        capture_dr = 1'b0; shift_dr = 1'b0; tdi = 1'b0;
        for (int i = 0; i < DR_W; i++) begin
            checks++; if (tdo !== exp_sr[i]) begin failures++;
                $display("FAIL prio_tdo[%0d] got=%b exp=%b", i, tdo, exp_sr[i]); end
            shift_dr = 1'b1; step();
        end
        shift_dr = 1'b0;
    endtask

    task automatic test_ir_coincident();
        logic [DR_W-1:0] w;
        w = {1'b0, 37'h1_1111_2222};
        load_ir(2'b00);
        shift_word(w);
        ir_in = 2'b11; update_ir = 1'b1; update_dr = 1'b1; step();
        update_ir = 1'b0; update_dr = 1'b0;
        checks++; if (take_no_action !== 4'b0001 || ir_q !== 2'b11) begin failures++;
            $display("FAIL ir_coinc pulse=%b ir=%b exp 0001/11", take_no_action, ir_q); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [DR_W-1:0] w;
        w = {1'b1, 37'h0_DEAD_BEEF};
        load_ir(2'b10);
        shift_word(w);
        update_dr = 1'b1; step(); update_dr = 1'b0; step();
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (busy !== 1'b0 || jdo !== '0 || ir_q !== '0 || take_action !== '0) begin failures++;
            $display("FAIL rst_mid busy=%b jdo=%h ir=%b pulse=%b exp 0", busy, jdo, ir_q, take_action); end
        shift_word(w);
        reset = 1'b1; update_dr = 1'b1; step(); reset = 1'b0; update_dr = 1'b0;
        checks++; if (take_action !== '0 || take_no_action !== '0 || busy !== 1'b0) begin failures++;
            $display("FAIL rst_coinc pulse=%b/%b busy=%b exp 0", take_action, take_no_action, busy); end
        shift_word(w);
        update_dr = 1'b1; step(); update_dr = 1'b0;
        checks++; if (jdo !== w || take_action !== 4'b0001 || busy !== 1'b1) begin failures++;
            $display("FAIL rst_after jdo=%h pulse=%b busy=%b exp %h/0001/1", jdo, take_action, busy, w); end
        step();
        action_ack = 1'b1; step(); action_ack = 1'b0;
    endtask

    // Random commands against a transaction-level model of one command's life.
    task automatic test_random();
        logic [DR_W-1:0] w;
        logic [IR_W-1:0] c;
        logic [NCH-1:0]  exp_a, exp_n;
        int              waitc;
        for (int n = 0; n < 16; n++) begin
            w = {$urandom, $urandom} & {DR_W{1'b1}};
            c = IR_W'($urandom_range(0, NCH-1));
            waitc = $urandom_range(0, 3);
            load_ir(c);
            shift_word(w);
            update_dr = 1'b1; step(); update_dr = 1'b0;
            exp_a = w[DR_W-1] ? onehot(c) : '0;
            exp_n = w[DR_W-1] ? '0 : onehot(c);
            checks++; if (jdo !== w || take_action !== exp_a || take_no_action !== exp_n) begin failures++;
                $display("FAIL rnd[%0d] jdo=%h a=%b n=%b exp %h/%b/%b", n, jdo, take_action, take_no_action, w, exp_a, exp_n); end
            for (int k = 0; k <= waitc; k++) begin
                step();
                checks++; if (busy !== (HS & w[DR_W-1]) || take_action !== '0 || take_no_action !== '0) begin failures++;
                    $display("FAIL rnd_wait[%0d] busy=%b exp=%b", n, busy, HS & w[DR_W-1]); end
            end
            action_ack = 1'b1; step(); action_ack = 1'b0;
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_ack[%0d] busy=%b exp=0", n, busy); end
        end
    endtask

    initial begin
        reset = 1'b1; ir_in = '0; update_ir = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0;
        update_dr = 1'b0; tdi = 1'b0; capture_data = '0; action_ack = 1'b0;
        test_reset();
        test_action_and_capture();
        test_no_action();
        test_back_to_back();
        test_capture_priority();
        test_ir_coincident();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
